next_pc_gen_mod: RTL and testbench
==================================

Name: next_pc_gen_mod

Overview:
Fetch-side next-PC generator sitting directly upstream of the program counter register. Each cycle it takes the current PC, looks it up in a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and drives the 32-bit next PC and the PC enable. It also applies EX-stage branch resolution: it trains the BTB and redirects fetch on a misprediction.

Parameters:
N, 10, PC width in bits; byte-addressable, word-aligned instructions.
ENTRIES, 16, BTB entry count; power of two, at least 2.
IDX_W, $clog2(ENTRIES), index width; derived, not to be overridden.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pc_i  input  N  current PC (registered PC output)
stall_i  input  1  fetch stall from hazard unit
ex_valid_i  input  1  EX-stage resolution valid
ex_is_branch_i  input  1  resolved instruction is a branch or jump
ex_pc_i  input  N  PC of resolved instruction
ex_taken_i  input  1  actual direction
ex_target_i  input  N  actual taken target
ex_mispredict_i  input  1  EX detected misprediction
ex_correct_pc_i  input  N  correct fetch PC on misprediction
next_pc_o  output  32  next PC, zero-extended from N bits
pc_enable_o  output  1  PC register load enable
pred_taken_o  output  1  prediction for pc_i; piped down to EX
flush_o  output  1  flush IF/ID and ID/EX this cycle

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset: all BTB valid bits = 0, tags/targets = 0, counters = 2'b01 (weakly not-taken). Outputs derive combinationally from state, so during reset: pred_taken_o = 0, flush_o = 0, pc_enable_o = ~stall_i, next_pc_o = pc_i+4.
- Address split: index = pc[IDX_W+1:2]; tag = pc[N-1:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational, zero latency): hit = valid[idx] && tag[idx] == tag(pc_i).
  - Predict taken if hit && counter[idx][1].
  - Sequential PC = (pc_i + 4) mod 2^N; wraps, e.g. 1020 -> 0 for N=10.
- next_pc_o priority:
  1. ex_valid_i && ex_mispredict_i -> ex_correct_pc_i.
  2. Predicted taken -> stored target.
  3. Otherwise -> sequential PC.
- pc_enable_o = ~stall_i | (ex_valid_i & ex_mispredict_i). A redirect overrides a stall.
- flush_o = ex_valid_i & ex_mispredict_i.
- pred_taken_o: predicted-taken result for pc_i; forced 0 when a redirect is active.
- Update (registered, on posedge clk, when ex_valid_i && ex_is_branch_i; independent of stall_i):
  - Hit, taken: counter increments, saturating at 11; target <= ex_target_i.
  - Hit, not taken: counter decrements, saturating at 00; target unchanged.
  - Miss, taken: allocate/replace entry: valid = 1, tag, target, counter = 10.
  - Miss, not taken: no change.
- Lookup/update collision on the same index in one cycle: lookup sees pre-update contents. No bypass; the update is visible next cycle.
- ex_valid_i with ex_is_branch_i = 0: no BTB change. A redirect is still honoured if ex_mispredict_i = 1.
- Reset asserted mid-operation clears all state immediately; no pending update survives.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined: adds three 16-bit saturating counters: lookups (each cycle pc_enable_o = 1), hits (lookup hit), mispredicts (flush_o). Exposed on output ports stat_lookups_o, stat_hits_o and stat_mispredicts_o. All reset to 0 and hold at 16'hFFFF.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Package btb_pkg:
  - btb_entry_t struct: valid, tag, target, ctr[1:0].
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - PC increment constant PC_STEP = 4.
- Sub-module btb_table_mod: the storage array, with one async read port (lookup) and one sync write port (update), plus reset clear.
- Counter saturation and next-PC selection stay in the top level.

Test Plan:
- Reset with pc_i = 0, stall_i = 0 -> next_pc_o = 4, pred_taken_o = 0, pc_enable_o = 1, flush_o = 0; with BTB_STATS_EN, all stats = 0.
- pc_i = 1020, empty BTB -> next_pc_o = 0 (wrap), pred_taken_o = 0.
- Taken update at ex_pc = 0x040, target 0x100; next cycle pc_i = 0x040 -> next_pc_o = 0x100, pred_taken_o = 1.
- Two not-taken updates at 0x040 (counter 10 -> 01 -> 00) -> pc_i = 0x040 gives next_pc_o = 0x044, pred_taken_o = 0. Two more taken updates -> predicts 0x100 again.
- stall_i = 1 with ex_mispredict_i = 1, ex_correct_pc_i = 0x200 -> pc_enable_o = 1, next_pc_o = 0x200, flush_o = 1, pred_taken_o = 0.
- Alias test: entry for 0x040 trained taken; pc_i = 0x080 (same index, different tag) -> miss, next_pc_o = 0x084. Taken update at 0x080 replaces the entry; 0x040 then misses.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the next-PC generator and its BTB storage.
// Entry fields are held at full 32-bit width so every next-PC source is already zero-extended.
package btb_pkg;

    localparam int PC_MAX_W = 32;
    localparam int PC_STEP  = 4;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [PC_MAX_W-1:0] tag;
        logic [PC_MAX_W-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

endpackage

// File: rtl/btb_table_mod.sv
// Direct-mapped BTB storage: async lookup read, async probe read for the update side,
// one synchronous write port, and asynchronous clear of every entry.
module btb_table_mod
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lk_idx_i,
    output btb_entry_t       lk_entry_o,
    input  logic [IDX_W-1:0] pr_idx_i,
    output btb_entry_t       pr_entry_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  btb_entry_t       wr_entry_i
);

    btb_entry_t entries_q [ENTRIES];
    btb_entry_t entries_d [ENTRIES];

    always_comb begin
        entries_d = entries_q;
        if (wr_en_i) begin
            entries_d[wr_idx_i] = wr_entry_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= BTB_RST_ENTRY;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    // Reads see pre-write contents; a same-cycle update becomes visible next cycle.
    assign lk_entry_o = entries_q[lk_idx_i];
    assign pr_entry_o = entries_q[pr_idx_i];

endmodule

// File: rtl/next_pc_gen_mod.sv
// Fetch-side next-PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Optional BTB_STATS_EN adds saturating lookup/hit/mispredict counters on extra outputs.
module next_pc_gen_mod
    import btb_pkg::*;
#(
    parameter int  N       = 10,
    parameter int  ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pc_i,
    input  logic         stall_i,
    input  logic         ex_valid_i,
    input  logic         ex_is_branch_i,
    input  logic [N-1:0] ex_pc_i,
    input  logic         ex_taken_i,
    input  logic [N-1:0] ex_target_i,
    input  logic         ex_mispredict_i,
    input  logic [N-1:0] ex_correct_pc_i,
    output logic [31:0]  next_pc_o,
    output logic         pc_enable_o,
    output logic         pred_taken_o,
    output logic         flush_o
`ifdef BTB_STATS_EN
    ,
    output logic [15:0]  stat_lookups_o,
    output logic [15:0]  stat_hits_o,
    output logic [15:0]  stat_mispredicts_o
`endif
);

    btb_entry_t          lk_entry;
    btb_entry_t          pr_entry;
    btb_entry_t          upd_entry;
    logic                upd_en;
    logic [IDX_W-1:0]    lk_idx;
    logic [IDX_W-1:0]    pr_idx;
    logic [PC_MAX_W-1:0] lk_tag;
    logic [PC_MAX_W-1:0] pr_tag;
    logic                lk_hit;
    logic                lk_taken;
    logic                pr_hit;
    logic                redirect;
    logic [N-1:0]        seq_pc;
    logic                unused_bits;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == ST) ? ST : c + 2'd1;
        end
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    btb_table_mod #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_idx_i   (lk_idx),
        .lk_entry_o (lk_entry),
        .pr_idx_i   (pr_idx),
        .pr_entry_o (pr_entry),
        .wr_en_i    (upd_en),
        .wr_idx_i   (pr_idx),
        .wr_entry_i (upd_entry)
    );

    assign lk_idx   = pc_i[IDX_W+1:2];
    assign lk_tag   = PC_MAX_W'(pc_i[N-1:IDX_W+2]);
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign lk_taken = lk_hit && lk_entry.ctr[1];

    assign pr_idx   = ex_pc_i[IDX_W+1:2];
    assign pr_tag   = PC_MAX_W'(ex_pc_i[N-1:IDX_W+2]);
    assign pr_hit   = pr_entry.valid && (pr_entry.tag == pr_tag);

    assign seq_pc   = pc_i + N'(PC_STEP);
    assign redirect = ex_valid_i & ex_mispredict_i;

    assign unused_bits = ^{ex_pc_i[1:0], lk_entry.ctr[0]};

    always_comb begin
        if (redirect) begin
            next_pc_o = PC_MAX_W'(ex_correct_pc_i);
        end else if (lk_taken) begin
            next_pc_o = lk_entry.target;
        end else begin
            next_pc_o = PC_MAX_W'(seq_pc);
        end
    end

    assign pc_enable_o  = ~stall_i | redirect;
    assign flush_o      = redirect;
    assign pred_taken_o = lk_taken & ~redirect;

    // Training ignores stall_i; a miss that resolves not-taken leaves the entry alone.
    always_comb begin
        upd_en    = 1'b0;
        upd_entry = pr_entry;
        if (ex_valid_i && ex_is_branch_i) begin
            if (pr_hit) begin
                upd_en        = 1'b1;
                upd_entry.ctr = ctr_step(pr_entry.ctr, ex_taken_i);
                if (ex_taken_i) begin
                    upd_entry.target = PC_MAX_W'(ex_target_i);
                end
            end else if (ex_taken_i) begin
                upd_en    = 1'b1;
                upd_entry = '{valid: 1'b1, tag: pr_tag, target: PC_MAX_W'(ex_target_i), ctr: WT};
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups_q, stat_lookups_d;
    logic [15:0] stat_hits_q, stat_hits_d;
    logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        stat_lookups_d     = sat_inc(stat_lookups_q, pc_enable_o);
        stat_hits_d        = sat_inc(stat_hits_q, pc_enable_o & lk_hit);
        stat_mispredicts_d = sat_inc(stat_mispredicts_q, flush_o);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups_o     = stat_lookups_q;
    assign stat_hits_o        = stat_hits_q;
    assign stat_mispredicts_o = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_next_pc_gen_mod.sv
// Bench for next_pc_gen_mod: per-cycle comparison against an abstract BTB model plus directed literals.
module tb_next_pc_gen_mod;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pc_i;
    logic        stall_i;
    logic        ex_valid_i;
    logic        ex_is_branch_i;
    logic [9:0]  ex_pc_i;
    logic        ex_taken_i;
    logic [9:0]  ex_target_i;
    logic        ex_mispredict_i;
    logic [9:0]  ex_correct_pc_i;
    logic [31:0] next_pc_o;
    logic        pc_enable_o;
    logic        pred_taken_o;
    logic        flush_o;
`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups_o;
    logic [15:0] stat_hits_o;
    logic [15:0] stat_mispredicts_o;
`endif

    int checks   = 0;
    int failures = 0;

    int m_valid  [16];
    int m_tag    [16];
    int m_target [16];
    int m_ctr    [16];

    always #5 clk = ~clk;

    next_pc_gen_mod dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_i            (pc_i),
        .stall_i         (stall_i),
        .ex_valid_i      (ex_valid_i),
        .ex_is_branch_i  (ex_is_branch_i),
        .ex_pc_i         (ex_pc_i),
        .ex_taken_i      (ex_taken_i),
        .ex_target_i     (ex_target_i),
        .ex_mispredict_i (ex_mispredict_i),
        .ex_correct_pc_i (ex_correct_pc_i),
        .next_pc_o       (next_pc_o),
        .pc_enable_o     (pc_enable_o),
        .pred_taken_o    (pred_taken_o),
        .flush_o         (flush_o)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups_o     (stat_lookups_o),
        .stat_hits_o        (stat_hits_o),
        .stat_mispredicts_o (stat_mispredicts_o)
`endif
    );

    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    // Model: BTB as plain integer arrays, trained by the direction/target rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
            end
        end else if (ex_valid_i && ex_is_branch_i) begin
            int idx, tg;
            idx = (int'(ex_pc_i) / 4) % 16;
            tg  = int'(ex_pc_i) / 64;
            if (m_valid[idx] != 0 && m_tag[idx] == tg) begin
                if (ex_taken_i) begin
                    m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_target[idx] = int'(ex_target_i);
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (ex_taken_i) begin
                m_valid[idx] = 1; m_tag[idx] = tg; m_target[idx] = int'(ex_target_i); m_ctr[idx] = 2;
            end
        end
    end

    always @(negedge clk) begin
        int idx, tg, exp_next;
        bit hit, pt, rd;
        idx = (int'(pc_i) / 4) % 16;
        tg  = int'(pc_i) / 64;
        hit = (m_valid[idx] != 0) && (m_tag[idx] == tg);
        pt  = hit && (m_ctr[idx] >= 2);
        rd  = ex_valid_i && ex_mispredict_i;
        exp_next = rd ? int'(ex_correct_pc_i) : (pt ? m_target[idx] : (int'(pc_i) + 4) % 1024);
        check("model_next_pc", next_pc_o, 32'(exp_next));
        check("model_pred", {31'd0, pred_taken_o}, {31'd0, pt && !rd});
        check("model_pc_en", {31'd0, pc_enable_o}, {31'd0, !stall_i || rd});
        check("model_flush", {31'd0, flush_o}, {31'd0, rd});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_none();
        ex_valid_i = 0; ex_is_branch_i = 0; ex_taken_i = 0; ex_mispredict_i = 0;
        ex_pc_i = '0; ex_target_i = '0; ex_correct_pc_i = '0;
    endtask

    task automatic ex_upd(input logic [9:0] p, input logic tk, input logic [9:0] tgt);
        ex_valid_i = 1; ex_is_branch_i = 1; ex_mispredict_i = 0;
        ex_pc_i = p; ex_taken_i = tk; ex_target_i = tgt;
    endtask

    task automatic lit_np(input string nm, input logic [31:0] exp_np, input logic exp_pt);
        #1;
        check({nm, "_next"}, next_pc_o, exp_np);
        check({nm, "_pred"}, {31'd0, pred_taken_o}, {31'd0, exp_pt});
    endtask

    initial begin
        rst_n = 0; pc_i = '0; stall_i = 0;
        ex_none();
        #3;
        check("rst_next", next_pc_o, 32'd4);
        check("rst_pred", {31'd0, pred_taken_o}, 32'd0);
        check("rst_en", {31'd0, pc_enable_o}, 32'd1);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
`ifdef BTB_STATS_EN
        check("rst_stat_lk", {16'd0, stat_lookups_o}, 32'd0);
        check("rst_stat_hit", {16'd0, stat_hits_o}, 32'd0);
        check("rst_stat_mp", {16'd0, stat_mispredicts_o}, 32'd0);
`endif
        stall_i = 1;
        #1 check("rst_stall_en", {31'd0, pc_enable_o}, 32'd0);
        stall_i = 0;
        tick();
        rst_n = 1;

        pc_i = 10'h3FC;
        lit_np("wrap", 32'h0, 1'b0);

        pc_i = 10'h040;
        ex_upd(10'h040, 1'b1, 10'h100);
        lit_np("collide", 32'h44, 1'b0);
        tick(); ex_none();
        lit_np("alloc", 32'h100, 1'b1);

        ex_upd(10'h040, 1'b0, 10'h0);
        tick();
        lit_np("nt1", 32'h44, 1'b0);
        tick();
        ex_upd(10'h040, 1'b1, 10'h100);
        lit_np("nt2", 32'h44, 1'b0);
        tick();
        lit_np("tk1", 32'h44, 1'b0);
        tick(); ex_none();
        lit_np("tk2", 32'h100, 1'b1);

        stall_i = 1; ex_valid_i = 1; ex_is_branch_i = 0; ex_mispredict_i = 1; ex_correct_pc_i = 10'h200;
        #1;
        check("redir_en", {31'd0, pc_enable_o}, 32'd1);
        check("redir_flush", {31'd0, flush_o}, 32'd1);
        lit_np("redir", 32'h200, 1'b0);
        tick(); ex_none();
        #1 check("stall_en", {31'd0, pc_enable_o}, 32'd0);
        lit_np("stall", 32'h100, 1'b1);
        stall_i = 0;

        pc_i = 10'h080;
        lit_np("alias_miss", 32'h84, 1'b0);
        ex_upd(10'h080, 1'b1, 10'h300);
        tick(); ex_none();
        lit_np("alias_new", 32'h300, 1'b1);
        pc_i = 10'h040;
        lit_np("alias_old", 32'h44, 1'b0);

        pc_i = 10'h080;
        ex_upd(10'h080, 1'b1, 10'h120);
        tick(); ex_none();
        lit_np("retarget", 32'h120, 1'b1);

        ex_upd(10'h010, 1'b0, 10'h0);
        tick(); ex_none();
        pc_i = 10'h010;
        lit_np("miss_nt", 32'h14, 1'b0);

        pc_i = 10'h080;
        rst_n = 0;
        lit_np("midrst", 32'h84, 1'b0);
        ex_upd(10'h080, 1'b1, 10'h120);
        tick();
        rst_n = 1; ex_none();
        lit_np("midrst_after", 32'h84, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic [9:0] picks [4];
            picks[0] = 10'h040; picks[1] = 10'h080; picks[2] = 10'h0C4; picks[3] = 10'(($urandom & 32'h3FC));
            pc_i            = picks[$urandom_range(0, 3)];
            stall_i         = ($urandom_range(0, 3) == 0);
            ex_valid_i      = $urandom_range(0, 1) == 1;
            ex_is_branch_i  = $urandom_range(0, 3) != 0;
            ex_pc_i         = picks[$urandom_range(0, 3)];
            ex_taken_i      = $urandom_range(0, 1) == 1;
            ex_target_i     = 10'(($urandom & 32'h3FC));
            ex_mispredict_i = ($urandom_range(0, 4) == 0);
            ex_correct_pc_i = 10'(($urandom & 32'h3FC));
            tick();
        end

        ex_none();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
